// File: rtl/cv32e40p_nmr_voter.sv
// N-modular-redundancy result voter: collects one result per replica, votes
// bitwise over the healthy replicas, and retires replicas that keep disagreeing
// or stall past the round timeout.
module cv32e40p_nmr_voter #(
  parameter int unsigned NREP      = 3,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned FAULT_THR = 3,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREP-1:0]        rep_valid_i,
  input  logic [NREP*WIDTH-1:0]  rep_result_i,
  input  logic [NREP-1:0]        rep_cmp_i,
  output logic [NREP-1:0]        rep_ready_o,
  input  logic                   clear_i,
  input  logic                   ex_ready_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       result_o,
  output logic                   comparison_result_o,
  output logic                   mismatch_o,
  output logic                   uncorrectable_o,
  output logic [NREP-1:0]        fault_mask_o,
  output logic [NREP*CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned PC_W  = $clog2(NREP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(FAULT_THR);
  localparam logic [TMR_W-1:0] TMO     = TMR_W'(TIMEOUT);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                        state_q, state_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic [NREP-1:0]               full_q, full_d, cmp_q, cmp_d;
  logic [NREP-1:0]               drop_q, drop_d, mask_q, mask_d;
  logic [NREP-1:0][WIDTH-1:0]    res_q, res_d;
  logic [NREP-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic                          valid_q, valid_d, vcmp_q, vcmp_d;
  logic                          mism_q, mism_d, unc_q, unc_d;
  logic [WIDTH-1:0]              result_q, result_d;

  logic [NREP-1:0]               part, missing, fire_miss, accept, inc, col;
  logic                          complete, fire, vote_cmp, tie, low_cmp;
  logic [WIDTH-1:0]              vote, low_res;
  logic [1:0]                    mj;
  logic [PC_W-1:0]               n_en;

  // Majority of the participating bits; a tie returns {1, lowest participant's bit}
  function automatic logic [1:0] maj(input logic [NREP-1:0] bits,
                                     input logic [NREP-1:0] p,
                                     input logic            lowbit);
    logic [PC_W:0] ones2;
    logic [PC_W:0] np;
    ones2 = '0;
    np    = '0;
    for (int i = 0; i < int'(NREP); i++) begin
      if (p[i]) begin
        np = np + (PC_W+1)'(1);
        if (bits[i]) ones2 = ones2 + (PC_W+1)'(2);
      end
    end
    if (ones2 > np)      return 2'b01;
    else if (ones2 < np) return 2'b00;
    else                 return {1'b1, lowbit};
  endfunction

  // Round status and per-replica handshake
  always_comb begin
    part        = ~mask_q & full_q;
    missing     = ~mask_q & ~full_q;
    complete    = (state_q == COLLECT) && ((missing == '0) || (timer_q == TMO));
    fire        = complete && (!valid_q || ex_ready_i);
    fire_miss   = fire ? missing : '0;
    rep_ready_o = mask_q | (~full_q & ~fire_miss);
    accept      = rep_valid_i & rep_ready_o;
  end

  // Bitwise vote over the participants
  always_comb begin
    low_res  = '0;
    low_cmp  = 1'b0;
    col      = '0;
    vote     = '0;
    vote_cmp = 1'b0;
    tie      = 1'b0;
    mj       = '0;
    for (int i = int'(NREP) - 1; i >= 0; i--) begin
      if (part[i]) begin
        low_res = res_q[i];
        low_cmp = cmp_q[i];
      end
    end
    for (int b = 0; b < int'(WIDTH); b++) begin
      for (int i = 0; i < int'(NREP); i++) col[i] = res_q[i][b];
      mj      = maj(col, part, low_res[b]);
      vote[b] = mj[0];
      tie     = tie | mj[1];
    end
    mj       = maj(cmp_q, part, low_cmp);
    vote_cmp = mj[0];
    tie      = tie | mj[1];
  end

  // Slot capture/release, error counting and replica retirement
  always_comb begin
    full_d = full_q;
    res_d  = res_q;
    cmp_d  = cmp_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    mask_d = mask_q;
    inc    = '0;
    n_en   = '0;
    for (int i = 0; i < int'(NREP); i++) begin
      if (fire && part[i]) full_d[i] = 1'b0;
      if (accept[i] && !mask_q[i]) begin
        if (drop_q[i]) begin
          drop_d[i] = 1'b0;
        end else begin
          full_d[i] = 1'b1;
          res_d[i]  = rep_result_i[i*WIDTH +: WIDTH];
          cmp_d[i]  = rep_cmp_i[i];
        end
      end
      inc[i] = fire_miss[i] |
               (fire & part[i] & ((res_q[i] != vote) | (cmp_q[i] != vote_cmp)));
      if (fire_miss[i]) drop_d[i] = 1'b1;
      if (inc[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (!mask_q[i]) n_en = n_en + PC_W'(1);
    end
    // Retire lowest index first, never dropping below two enabled replicas
    for (int i = 0; i < int'(NREP); i++) begin
      if (!mask_d[i] && (cnt_d[i] >= THR) && (n_en > PC_W'(2))) begin
        mask_d[i] = 1'b1;
        n_en      = n_en - PC_W'(1);
      end
    end
    if (clear_i) begin
      cnt_d  = '0;
      mask_d = '0;
      drop_d = '0;
    end
  end

  // Round FSM, timer and output register next-state
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    result_d = result_q;
    vcmp_d   = vcmp_q;
    unc_d    = unc_q;
    mism_d   = 1'b0;
    if (valid_q && ex_ready_i) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_d != '0) begin
          state_d = COLLECT;
          timer_d = TMR_W'(1);
        end
      end
      COLLECT: begin
        if (fire) begin
          state_d  = IDLE;
          timer_d  = '0;
          valid_d  = 1'b1;
          result_d = vote;
          vcmp_d   = vote_cmp;
          unc_d    = tie;
          mism_d   = |inc;
        end else if (!complete) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      full_q   <= '0;
      res_q    <= '0;
      cmp_q    <= '0;
      drop_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      vcmp_q   <= 1'b0;
      unc_q    <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      full_q   <= full_d;
      res_q    <= res_d;
      cmp_q    <= cmp_d;
      drop_q   <= drop_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      vcmp_q   <= vcmp_d;
      unc_q    <= unc_d;
      mism_q   <= mism_d;
    end
  end

  assign valid_o             = valid_q;
  assign result_o            = result_q;
  assign comparison_result_o = vcmp_q;
  assign mismatch_o          = mism_q;
  assign uncorrectable_o     = unc_q;
  assign fault_mask_o        = mask_q;
  assign err_cnt_o           = cnt_q;

endmodule

// File: tb/tb_cv32e40p_nmr_voter.sv
// Scoreboard bench for cv32e40p_nmr_voter: a round-level model predicts each
// voted output and the counter/mask state; a monitor checks what the DUT presents.
module tb_cv32e40p_nmr_voter;

  localparam int unsigned NREP = 3, W = 32, CNT_W = 4, FAULT_THR = 3, TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREP-1:0]       rep_valid_i = '0;
  logic [NREP*W-1:0]     rep_result_i = '0;
  logic [NREP-1:0]       rep_cmp_i = '0;
  logic [NREP-1:0]       rep_ready_o;
  logic                  clear_i = 1'b0;
  logic                  ex_ready_i = 1'b1;
  logic                  valid_o, comparison_result_o, mismatch_o, uncorrectable_o;
  logic [W-1:0]          result_o;
  logic [NREP-1:0]       fault_mask_o;
  logic [NREP*CNT_W-1:0] err_cnt_o;

  cv32e40p_nmr_voter #(.NREP(NREP), .WIDTH(W), .CNT_W(CNT_W),
                       .FAULT_THR(FAULT_THR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rep_valid_i(rep_valid_i), .rep_result_i(rep_result_i),
    .rep_cmp_i(rep_cmp_i), .rep_ready_o(rep_ready_o), .clear_i(clear_i),
    .ex_ready_i(ex_ready_i), .valid_o(valid_o), .result_o(result_o),
    .comparison_result_o(comparison_result_o), .mismatch_o(mismatch_o),
    .uncorrectable_o(uncorrectable_o), .fault_mask_o(fault_mask_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cmp;
    logic         unc;
    logic         mm;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              rdy_mode = 2;   // 0 random, 1 stall, 2 always ready
  int unsigned     m_cnt[NREP];
  logic [NREP-1:0] m_mask = '0;
  logic [NREP-1:0] m_drop = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [NREP*CNT_W-1:0] m_cnt_flat();
    logic [NREP*CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NREP); i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return r;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < int'(NREP); i++) m_cnt[i] = 0;
    m_mask = '0;
    m_drop = '0;
  endtask

  // Round-level reference: who takes part, the majority vote, and the bookkeeping
  task automatic model_round(input logic [NREP-1:0] pres, input logic [NREP*W-1:0] vals,
                             input logic [NREP-1:0] cmps, input bit clr);
    logic [NREP-1:0] en, part, miss;
    int np, ones, lo;
    bit bad;
    exp_t e;
    en = ~m_mask;
    part = '0;
    for (int i = 0; i < int'(NREP); i++)
      if (pres[i] && en[i]) begin
        if (m_drop[i]) m_drop[i] = 1'b0;
        else part[i] = 1'b1;
      end
    if (part == '0) return;
    miss = en & ~part;
    np = $countones(part);
    lo = 0;
    for (int i = int'(NREP) - 1; i >= 0; i--) if (part[i]) lo = i;
    e = '0;
    for (int b = 0; b < int'(W); b++) begin
      ones = 0;
      for (int i = 0; i < int'(NREP); i++) if (part[i] && vals[i*W+b]) ones++;
      if (2*ones > np) e.res[b] = 1'b1;
      else if (2*ones < np) e.res[b] = 1'b0;
      else begin e.res[b] = vals[lo*W+b]; e.unc = 1'b1; end
    end
    ones = 0;
    for (int i = 0; i < int'(NREP); i++) if (part[i] && cmps[i]) ones++;
    if (2*ones > np) e.cmp = 1'b1;
    else if (2*ones < np) e.cmp = 1'b0;
    else begin e.cmp = cmps[lo]; e.unc = 1'b1; end
    for (int i = 0; i < int'(NREP); i++) begin
      bad = miss[i] || (part[i] && ((vals[i*W +: W] != e.res) || (cmps[i] != e.cmp)));
      if (bad) begin
        e.mm = 1'b1;
        if (m_cnt[i] < (2**CNT_W) - 1) m_cnt[i]++;
      end
      if (miss[i]) m_drop[i] = 1'b1;
    end
    for (int i = 0; i < int'(NREP); i++)
      if (!m_mask[i] && m_cnt[i] >= FAULT_THR && $countones(~m_mask) > 2) m_mask[i] = 1'b1;
    if (clr) model_zero();
    q.push_back(e);
  endtask

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ex_ready_i = ($urandom % 4) != 0;
      1:       ex_ready_i = 1'b0;
      default: ex_ready_i = 1'b1;
    endcase
  end

  // Monitor: new presentations pop the scoreboard, held ones must not move
  exp_t mon_last;
  bit   held = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (valid_o) begin
      if (!held) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(result_o), 64'hDEAD);
        end else begin
          mon_last = q.pop_front();
          chk("result", 64'(result_o), 64'(mon_last.res));
          chk("cmp", 64'(comparison_result_o), 64'(mon_last.cmp));
          chk("uncorrectable", 64'(uncorrectable_o), 64'(mon_last.unc));
          chk("mismatch", 64'(mismatch_o), 64'(mon_last.mm));
        end
      end else begin
        chk("held_result", 64'(result_o), 64'(mon_last.res));
        chk("held_cmp", 64'(comparison_result_o), 64'(mon_last.cmp));
        chk("held_unc", 64'(uncorrectable_o), 64'(mon_last.unc));
        chk("held_mismatch_pulse", 64'(mismatch_o), 64'd0);
      end
      held = !ex_ready_i;
    end else begin
      held = 1'b0;
    end
  end

  task automatic present(input logic [NREP-1:0] pres, input logic [NREP*W-1:0] vals,
                         input logic [NREP-1:0] cmps);
    logic [NREP-1:0] pend, acc;
    int n;
    rep_result_i = vals;
    rep_cmp_i    = cmps;
    rep_valid_i  = pres;
    pend = pres;
    n = 0;
    while (pend != '0 && n < 100) begin
      @(negedge clk);
      acc = pend & rep_ready_o;
      @(posedge clk); #1;
      pend = pend & ~acc;
      rep_valid_i = pend;
      n++;
    end
    rep_valid_i = '0;
    chk("handshake_pending", 64'(pend), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || valid_o) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(n >= 400), 64'd0);
  endtask

  task automatic check_state();
    chk("err_cnt", 64'(err_cnt_o), 64'(m_cnt_flat()));
    chk("fault_mask", 64'(fault_mask_o), 64'(m_mask));
  endtask

  task automatic run_round(input logic [NREP-1:0] pres, input logic [NREP*W-1:0] vals,
                           input logic [NREP-1:0] cmps);
    model_round(pres, vals, cmps, 1'b0);
    present(pres, vals, cmps);
    wait_drain();
    check_state();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    model_zero();
  endtask

  function automatic logic [NREP*W-1:0] pack3(input logic [W-1:0] v2, input logic [W-1:0] v1,
                                               input logic [W-1:0] v0);
    return {v2, v1, v0};
  endfunction

  initial begin
    logic [NREP*W-1:0]     vals;
    logic [NREP-1:0]       pres, cmps, snap_mask;
    logic [NREP*CNT_W-1:0] snap_cnt;
    logic [W-1:0]          base, v;
    logic                  bc;
    int                    k;

    model_zero();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_flags", 64'({comparison_result_o, mismatch_o, uncorrectable_o}), 64'd0);
    chk("rst_ready", 64'(rep_ready_o), 64'h7);
    check_state();
    rst = 1'b0;
    @(posedge clk); #1;

    // One-cycle latency on a clean unanimous round
    vals = pack3(32'h1234, 32'h1234, 32'h1234);
    model_round(3'b111, vals, 3'b111, 1'b0);
    present(3'b111, vals, 3'b111);
    chk("latency_not_yet", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    chk("latency_valid", 64'(valid_o), 64'd1);
    wait_drain();
    check_state();

    // Replica 1 keeps disagreeing until it is retired
    vals = pack3(32'h1234, 32'h1235, 32'h1234);
    repeat (4) run_round(3'b111, vals, 3'b111);

    // Two enabled replicas tie: lowest index wins, no further retirement
    run_round(3'b111, pack3(32'h0, 32'h1, 32'hFFFF_0000), 3'b000);

    // Replica 2 stalls: forced round at TIMEOUT, then its next result is dropped
    pulse_clear();
    vals = pack3(32'h0, 32'h5A5A, 32'h5A5A);
    model_round(3'b011, vals, 3'b000, 1'b0);
    present(3'b011, vals, 3'b000);
    for (int c = 1; c < int'(TIMEOUT); c++) begin @(posedge clk); #1; end
    chk("timeout_early", 64'(valid_o), 64'd0);
    chk("late_ready_low", 64'(rep_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("timeout_fire", 64'(valid_o), 64'd1);
    wait_drain();
    check_state();
    run_round(3'b111, pack3(32'h77, 32'h77, 32'h77), 3'b111);

    // Downstream stall: outputs hold, next round waits, then fires on release
    pulse_clear();
    rdy_mode = 1;
    vals = pack3(32'hA, 32'hA, 32'hA);
    model_round(3'b111, vals, 3'b000, 1'b0);
    present(3'b111, vals, 3'b000);
    @(posedge clk); #1;
    snap_cnt = m_cnt_flat();
    snap_mask = m_mask;
    vals = pack3(32'hB, 32'hB, 32'hB);
    model_round(3'b111, vals, 3'b111, 1'b0);
    present(3'b111, vals, 3'b111);
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_valid", 64'(valid_o), 64'd1);
    chk("stall_result", 64'(result_o), 64'hA);
    chk("stall_ready", 64'(rep_ready_o), 64'(snap_mask));
    chk("stall_cnt", 64'(err_cnt_o), 64'(snap_cnt));
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("release_fire", 64'({valid_o, result_o}), 64'({1'b1, 32'hB}));
    wait_drain();
    check_state();

    // clear_i in the fire cycle beats the increment
    vals = pack3(32'h9, 32'h8, 32'h9);
    model_round(3'b111, vals, 3'b111, 1'b1);
    present(3'b111, vals, 3'b111);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    wait_drain();
    check_state();

    // Reset in the middle of a round with a held output
    rdy_mode = 1;
    vals = pack3(32'h77, 32'h55, 32'h55);
    model_round(3'b111, vals, 3'b000, 1'b0);
    present(3'b111, vals, 3'b000);
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    check_state();
    rep_result_i = pack3(32'h0, 32'h0, 32'h33);
    rep_valid_i = 3'b001;
    @(posedge clk); #1;
    rep_valid_i = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_flags", 64'({comparison_result_o, mismatch_o, uncorrectable_o}), 64'd0);
    chk("arst_ready", 64'(rep_ready_o), 64'h7);
    model_zero();
    q.delete();
    check_state();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;

    // Randomized rounds
    for (int r = 0; r < 150; r++) begin
      base = $urandom;
      bc = 1'($urandom % 2);
      for (int i = 0; i < int'(NREP); i++) begin
        pres[i] = ($urandom % 10) != 0;
        k = int'($urandom % 8);
        v = base;
        if (k == 0) v = $urandom;
        else if (k < 3) v = base ^ (32'd1 << ($urandom % 32));
        vals[i*W +: W] = v;
        cmps[i] = (($urandom % 6) == 0) ? ~bc : bc;
      end
      run_round(pres, vals, cmps);
      if ((r % 25) == 24) pulse_clear();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
